// File: rtl/mcpu_alu_pkg.sv
// mcpu_alu_pkg -- shared constants for the mcpu_alu block.
//   op_e           : opcode encodings (AND, OR, XOR, ADD)
//   CMD_SIZE_DEF   : default opcode width
//   WORD_SIZE_DEF  : default operand width
package mcpu_alu_pkg;

   localparam int CMD_SIZE_DEF  = 2;
   localparam int WORD_SIZE_DEF = 8;

   typedef enum logic [1:0] {
      OP_AND = 2'd0,
      OP_OR  = 2'd1,
      OP_XOR = 2'd2,
      OP_ADD = 2'd3
   } op_e;

endpackage

// File: rtl/mcpu_alu_core.sv
// mcpu_alu_core -- combinational datapath of mcpu_alu.
//   opcode [CMD_SIZE]      : operation select
//   r1, r2 [WORD_SIZE]     : unsigned operands
//   result [2*WORD_SIZE+1] : {overflow, out} before the result register
// Opcodes outside the four defined encodings produce zero.
module mcpu_alu_core
   import mcpu_alu_pkg::*;
#(
   parameter int CMD_SIZE  = CMD_SIZE_DEF,
   parameter int WORD_SIZE = WORD_SIZE_DEF
) (
   input  logic [CMD_SIZE-1:0]    opcode,
   input  logic [WORD_SIZE-1:0]   r1,
   input  logic [WORD_SIZE-1:0]   r2,
   output logic [2*WORD_SIZE:0]   result
);

   localparam int RW = 2*WORD_SIZE + 1;

   always_comb begin
      result = '0;
      case (opcode)
         CMD_SIZE'(OP_AND): result = RW'(r1 & r2);
         CMD_SIZE'(OP_OR):  result = RW'(r1 | r2);
         CMD_SIZE'(OP_XOR): result = RW'(r1 ^ r2);
         // Widen before adding so the carry lands in bit WORD_SIZE.
         CMD_SIZE'(OP_ADD): result = RW'(r1) + RW'(r2);
         default:           result = '0;
      endcase
   end

endmodule

// File: rtl/mcpu_alu.sv
// mcpu_alu -- single-cycle registered ALU.
//   clk, rst_n      : clock, synchronous active-low reset
//   in_valid        : opcode/operands valid this cycle
//   opcode, r1, r2  : operation select and unsigned operands
//   out             : registered result [2*WORD_SIZE-1:0]
//   OVERFLOW        : registered result bit 2*WORD_SIZE
//   out_valid       : out/OVERFLOW updated by the previous edge
//   ZERO            : only with MCPU_ALU_ZERO_FLAG_EN defined; set when the
//                     registered {OVERFLOW,out} is all zero
// Result holds when in_valid is low; out_valid pulses once per accepted op.
module mcpu_alu
   import mcpu_alu_pkg::*;
#(
   parameter int CMD_SIZE  = CMD_SIZE_DEF,
   parameter int WORD_SIZE = WORD_SIZE_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [CMD_SIZE-1:0]    opcode,
   input  logic [WORD_SIZE-1:0]   r1,
   input  logic [WORD_SIZE-1:0]   r2,
   output logic [2*WORD_SIZE-1:0] out,
   output logic                   OVERFLOW,
`ifdef MCPU_ALU_ZERO_FLAG_EN
   output logic                   ZERO,
`endif
   output logic                   out_valid
);

   logic [2*WORD_SIZE:0]   w_res;
   logic [2*WORD_SIZE-1:0] r_out;
   logic                   r_ovf;
   logic                   r_valid;

   mcpu_alu_core #(
      .CMD_SIZE  (CMD_SIZE),
      .WORD_SIZE (WORD_SIZE)
   ) u_core (
      .opcode (opcode),
      .r1     (r1),
      .r2     (r2),
      .result (w_res)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out   <= '0;
         r_ovf   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_out <= w_res[2*WORD_SIZE-1:0];
            r_ovf <= w_res[2*WORD_SIZE];
         end
      end
   end

`ifdef MCPU_ALU_ZERO_FLAG_EN
   logic r_zero;

   // Tracks the held result, so it only updates alongside out.
   always_ff @(posedge clk) begin
      if (!rst_n)        r_zero <= 1'b0;
      else if (in_valid) r_zero <= (w_res == '0);
   end

   assign ZERO = r_zero;
`endif

   assign out       = r_out;
   assign OVERFLOW  = r_ovf;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_mcpu_alu.sv
// tb_mcpu_alu -- directed-vector bench for mcpu_alu, plus a second instance
// with CMD_SIZE=3 to reach the undefined opcodes, and a randomized sweep.
// Define MCPU_ALU_ZERO_FLAG_EN on both RTL and bench to cover ZERO.
module tb_mcpu_alu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [1:0]  opcode;
   logic        op_hi;
   logic [2:0]  opcode3;
   logic [7:0]  r1, r2;
   logic [15:0] out, out3;
   logic        ovf, ovf3;
   logic        out_valid, out_valid3;
`ifdef MCPU_ALU_ZERO_FLAG_EN
   logic        zero, zero3;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign opcode3 = {op_hi, opcode};

   mcpu_alu #(.CMD_SIZE(2), .WORD_SIZE(8)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .opcode    (opcode),
      .r1        (r1),
      .r2        (r2),
      .out       (out),
      .OVERFLOW  (ovf),
`ifdef MCPU_ALU_ZERO_FLAG_EN
      .ZERO      (zero),
`endif
      .out_valid (out_valid)
   );

   mcpu_alu #(.CMD_SIZE(3), .WORD_SIZE(8)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .opcode    (opcode3),
      .r1        (r1),
      .r2        (r2),
      .out       (out3),
      .OVERFLOW  (ovf3),
`ifdef MCPU_ALU_ZERO_FLAG_EN
      .ZERO      (zero3),
`endif
      .out_valid (out_valid3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it in, sample 1 time unit after the edge.
   task automatic cyc(input logic rn, input logic v, input logic [1:0] op,
                      input logic [7:0] a, input logic [7:0] b);
      rst_n = rn; in_valid = v; opcode = op; r1 = a; r2 = b;
      @(posedge clk); #1;
   endtask

   logic [16:0] exp_res;

   initial begin
      op_hi = 1'b0;
      rst_n = 1'b0; in_valid = 1'b0; opcode = '0; r1 = '0; r2 = '0;
      #2;

      // Reset held two cycles with a valid ADD present
      cyc(1'b0, 1'b1, 2'd3, 8'd255, 8'd255);
      cyc(1'b0, 1'b1, 2'd3, 8'd255, 8'd255);
      chk("rst_res",   {15'd0, ovf, out}, 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
`ifdef MCPU_ALU_ZERO_FLAG_EN
      chk("rst_zero",  32'(zero), 32'd0);
`endif

      // Logic ops, r1=3 r2=2, back to back
      cyc(1'b1, 1'b1, 2'd0, 8'd3, 8'd2);
      chk("and_res", {15'd0, ovf, out}, 32'd2);
      chk("and_vld", 32'(out_valid), 32'd1);
      cyc(1'b1, 1'b1, 2'd1, 8'd3, 8'd2);
      chk("or_res",  {15'd0, ovf, out}, 32'd3);
      chk("or_vld",  32'(out_valid), 32'd1);
      cyc(1'b1, 1'b1, 2'd2, 8'd3, 8'd2);
      chk("xor_res", {15'd0, ovf, out}, 32'd1);

      // ADD boundaries
      cyc(1'b1, 1'b1, 2'd3, 8'd255, 8'd255);
      chk("add_max", {15'd0, ovf, out}, 32'h1FE);
`ifdef MCPU_ALU_ZERO_FLAG_EN
      chk("add_max_zero", 32'(zero), 32'd0);
`endif
      cyc(1'b1, 1'b1, 2'd3, 8'd0, 8'd0);
      chk("add_zero", {15'd0, ovf, out}, 32'd0);
`ifdef MCPU_ALU_ZERO_FLAG_EN
      chk("add_zero_zero", 32'(zero), 32'd1);
`endif

      // in_valid 1,0,1: out holds during the idle cycle
      cyc(1'b1, 1'b1, 2'd2, 8'hF0, 8'h0F);
      chk("tog1_res", {15'd0, ovf, out}, 32'hFF);
      chk("tog1_vld", 32'(out_valid), 32'd1);
      cyc(1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
      chk("tog0_res", {15'd0, ovf, out}, 32'hFF);
      chk("tog0_vld", 32'(out_valid), 32'd0);
      cyc(1'b1, 1'b1, 2'd0, 8'hAA, 8'h0F);
      chk("tog2_res", {15'd0, ovf, out}, 32'h0A);
      chk("tog2_vld", 32'(out_valid), 32'd1);

      // Single-cycle reset between two valid ADDs
      cyc(1'b1, 1'b1, 2'd3, 8'd1, 8'd2);
      chk("mid_a", {15'd0, ovf, out}, 32'd3);
      cyc(1'b0, 1'b1, 2'd3, 8'd100, 8'd100);
      chk("mid_rst_res", {15'd0, ovf, out}, 32'd0);
      chk("mid_rst_vld", 32'(out_valid), 32'd0);
      cyc(1'b1, 1'b1, 2'd3, 8'd7, 8'd8);
      chk("mid_b", {15'd0, ovf, out}, 32'd15);
      chk("mid_b_vld", 32'(out_valid), 32'd1);

      // Wide-opcode instance: defined op still works, undefined ops give 0
      op_hi = 1'b0;
      cyc(1'b1, 1'b1, 2'd3, 8'd200, 8'd100);
      chk("w3_add", {15'd0, ovf3, out3}, 32'd300);
      for (int k = 0; k < 4; k++) begin
         op_hi = 1'b1;
         cyc(1'b1, 1'b1, 2'(k), 8'hFF, 8'h5A);
         chk($sformatf("w3_undef%0d_res", 4 + k), {15'd0, ovf3, out3}, 32'd0);
         chk($sformatf("w3_undef%0d_vld", 4 + k), 32'(out_valid3), 32'd1);
      end
      op_hi = 1'b0;

      // Random sweep, every cycle valid
      for (int i = 0; i < 1000; i++) begin
         logic [1:0] op;
         logic [7:0] a, b;
         op = 2'($urandom_range(0, 3));
         a  = 8'($urandom);
         b  = 8'($urandom);
         case (op)
            2'd0:    exp_res = {9'd0, a & b};
            2'd1:    exp_res = {9'd0, a | b};
            2'd2:    exp_res = {9'd0, a ^ b};
            default: exp_res = 17'(a) + 17'(b);
         endcase
         cyc(1'b1, 1'b1, op, a, b);
         chk($sformatf("rnd%0d op%0d %0h %0h", i, op, a, b), {15'd0, ovf, out}, {15'd0, exp_res});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
